// File: rtl/mod_acc_pkg.sv
// mod_acc_pkg: FSM state type and default widths shared by mod_acc and mod_adder.
`ifndef BITWIDTH
`define BITWIDTH 16
`endif

package mod_acc_pkg;

    localparam int unsigned DEF_DW = `BITWIDTH;
    localparam int unsigned DEF_LW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_e;

endpackage

// File: rtl/mod_adder.sv
// mod_adder: combinational (a + b) mod Q with a single conditional subtract.
// Q = 0 degenerates to a plain DW-bit sum.
module mod_adder
    import mod_acc_pkg::*;
#(
    parameter int unsigned DW = DEF_DW
) (
    input  logic [DW-1:0] iData0,
    input  logic [DW-1:0] iData1,
    input  logic [DW-1:0] iQ,
    output logic [DW-1:0] oData
);

    logic [DW:0] w_sum;
    logic [DW:0] w_diff;
    logic        w_unused_msb;

    assign w_sum  = {1'b0, iData0} + {1'b0, iData1};
    assign w_diff = w_sum - {1'b0, iQ};

    // The carry-out is never part of the result; only the low DW bits are kept.
    assign {w_unused_msb, oData} = (w_sum >= {1'b0, iQ}) ? w_diff : w_sum;

endmodule

// File: rtl/mod_acc.sv
// mod_acc: accumulates iLen operands modulo a modulus latched at start, then offers the result.
// Define MOD_ACC_RANGE_CHK_EN to add a sticky oErr flag that skips operands >= Q.
`ifndef BITWIDTH
`define BITWIDTH 16
`endif

module mod_acc
    import mod_acc_pkg::*;
#(
    parameter int unsigned DW = `BITWIDTH,
    parameter int unsigned LW = DEF_LW
) (
    input  logic          iClk,
    input  logic          iRstN,
    input  logic          iEn,
    input  logic          iClr,
    input  logic [DW-1:0] iQ,
    input  logic [LW-1:0] iLen,
    input  logic          iValid,
    input  logic [DW-1:0] iData,
    output logic          oReady,
    output logic          oValid,
    output logic [DW-1:0] oData,
    input  logic          iReady,
    output logic          oBusy
`ifdef MOD_ACC_RANGE_CHK_EN
    ,
    output logic          oErr
`endif
);

    state_e        r_state;
    state_e        w_state_nxt;
    logic [DW-1:0] r_acc;
    logic [DW-1:0] w_acc_nxt;
    logic [LW-1:0] r_cnt;
    logic [LW-1:0] w_cnt_nxt;
    logic [DW-1:0] r_q;
    logic [DW-1:0] w_q_nxt;
    logic [LW-1:0] r_len;
    logic [LW-1:0] w_len_nxt;

    logic [DW-1:0] w_sum;
    logic [LW-1:0] w_cnt_inc;
    logic          w_accept;
    logic          w_start;
    logic          w_oor;

    mod_adder #(
        .DW(DW)
    ) u_mod_adder (
        .iData0(r_acc),
        .iData1(iData),
        .iQ    (r_q),
        .oData (w_sum)
    );

    assign oReady    = (r_state == ACC) && iEn;
    assign oValid    = (r_state == OUT);
    assign oData     = r_acc;
    assign oBusy     = (r_state != IDLE);
    assign w_accept  = iValid && oReady;
    assign w_start   = (r_state == IDLE) && iEn;
    assign w_cnt_inc = r_cnt + LW'(1);

`ifdef MOD_ACC_RANGE_CHK_EN
    assign w_oor = (r_q != '0) && (iData >= r_q);
`else
    assign w_oor = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_q_nxt     = r_q;
        w_len_nxt   = r_len;
        if (iClr) begin
            w_state_nxt = IDLE;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (iEn) begin
                        w_q_nxt     = iQ;
                        w_len_nxt   = iLen;
                        w_acc_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = (iLen == '0) ? OUT : ACC;
                    end
                end
                ACC: begin
                    if (w_accept) begin
                        w_cnt_nxt = w_cnt_inc;
                        // Out-of-range operands still count toward the length.
                        if (!w_oor) begin
                            w_acc_nxt = w_sum;
                        end
                        if (w_cnt_inc == r_len) begin
                            w_state_nxt = OUT;
                        end
                    end
                end
                OUT: begin
                    if (iReady) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_q     <= '0;
            r_len   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_q     <= w_q_nxt;
            r_len   <= w_len_nxt;
        end
    end

`ifdef MOD_ACC_RANGE_CHK_EN
    logic r_err;

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_err <= 1'b0;
        end else if (iClr || w_start) begin
            r_err <= 1'b0;
        end else if (w_accept && w_oor) begin
            r_err <= 1'b1;
        end
    end

    assign oErr = r_err;
`endif

endmodule

// File: doc/mod_acc.md
MOD_ACC -- requirements
Module: mod_acc

Interface
REQ-001 SHALL have parameter DW, default `BITWIDTH`, operand/modulus/result width.
REQ-002 SHALL have parameter LW, default 8, operand-count width.
REQ-003 SHALL have port iClk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port iRstN, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port iEn, input, 1: in IDLE, a start request; in ACC, an enable whose low level stalls.
REQ-006 SHALL have port iClr, input, 1, synchronous abort/clear.
REQ-007 SHALL have port iQ, input, DW, modulus, sampled at start.
REQ-008 SHALL have port iLen, input, LW, operand count, sampled at start.
REQ-009 SHALL have port iValid, input, 1, operand valid.
REQ-010 SHALL have port iData, input, DW, operand.
REQ-011 SHALL have port oReady, output, 1, operand accept.
REQ-012 SHALL have port oValid, output, 1, result valid.
REQ-013 SHALL have port oData, output, DW, result.
REQ-014 SHALL have port iReady, input, 1, result accept from downstream.
REQ-015 SHALL have port oBusy, output, 1, high whenever state is not IDLE.

Function
REQ-016 SHALL implement FSM IDLE -> ACC -> OUT -> IDLE.
REQ-017 IDLE, iEn=1, iLen!=0: SHALL latch iQ/iLen, clear accumulator and count, go to ACC next cycle.
REQ-018 IDLE, iEn=1, iLen=0: SHALL go directly to OUT with oData=0.
REQ-019 ACC: SHALL drive oReady=iEn; an operand is accepted on a cycle with iValid&&oReady.
REQ-020 ACC: with iEn=0, SHALL keep all state unchanged.
REQ-021 Per accepted operand: SHALL compute acc <= (acc+iData) mod Q as s=acc+iData (DW+1 bits), then s-Q if s>=Q, else s; count += 1.
REQ-022 Acceptance of operand number iLen: SHALL enter OUT next cycle; oValid=1 exactly one cycle after the final accepted operand's handshake edge.
REQ-023 OUT: SHALL hold oValid=1 and a stable oData regardless of iEn/iValid until iReady=1; on that edge, SHALL return to IDLE.
REQ-024 OUT and IDLE: SHALL hold oReady=0.
REQ-025 Latched Q=1: SHALL yield result 0.
REQ-026 Latched Q=0: SHALL yield the plain sum mod 2^DW (the subtract is a no-op).
REQ-027 iClr=1 in any state: SHALL go to IDLE, zero acc/count, oValid=0 next cycle; iClr SHALL take priority over start and handshakes in the same cycle.
REQ-028 iQ/iLen changes after start SHALL have no effect until the next start.

Reset
REQ-029 On iRstN=0: SHALL set state=IDLE, acc=0, count=0, oValid=0, oReady=0, oData=0, oBusy=0 immediately, independent of iClk.
REQ-030 Reset mid-operation: SHALL discard the partial accumulation; no result SHALL be emitted.

Configuration
REQ-031 Macro MOD_ACC_RANGE_CHK_EN defined: SHALL add output oErr (1 bit); an accepted operand with iData>=Q (Q!=0) SHALL not be added, SHALL still count, and SHALL set sticky oErr; oErr SHALL clear on start, iClr or reset.
REQ-032 Macro absent: SHALL have no oErr port and no check; an out-of-range operand SHALL pass through the single conditional subtract, truncated to DW.

Structure
REQ-033 Package mod_acc_pkg SHALL hold the FSM state enum typedef (IDLE/ACC/OUT) and the default widths.
REQ-034 The modular add SHALL be an instance of the existing combinational mod_adder (iData0=acc, iData1=iData, iQ=latched Q); mod_acc SHALL contain no other sub-module.

Verification
REQ-035 Q=23, Len=2, data 10,20 -> oValid with oData=7; oBusy low after iReady.
REQ-036 Q=32, Len=3, data 10,20,5 -> oData=3; repeat with iValid gaps and iEn low mid-stream -> same result, no extra acceptances.
REQ-037 Len=0, iEn pulse -> OUT with oData=0 one cycle later; hold iReady=0 for 5 cycles -> oValid/oData stable throughout.
REQ-038 iClr after 1 of 3 operands -> IDLE next cycle, no oValid; restart with Q=24, data 10,20 (Len=2) -> oData=6.
REQ-039 Assert iRstN=0 between clock edges during ACC -> outputs zero immediately.
REQ-040 With MOD_ACC_RANGE_CHK_EN, Q=23, Len=2, data 25,4 -> oErr=1, oData=4; next start clears oErr.
